// File: rtl/multi_byte_add_seq.sv
// Sequential wide adder: one shared 8-bit adder walks NBYTES limbs, one per clock.
// Optional ADD_SUB_EN macro adds subtraction (B inverted, carry-in forced to 1).

module add8 (
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);
    assign {co, s} = {1'b0, x} + {1'b0, y} + {8'b0, ci};
endmodule

module multi_byte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  cin,
    input  logic                  sub,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   sum,
    output logic                  cout,
    output logic                  ovf
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            carry;
    logic [IW-1:0]   idx;

    logic [W-1:0]    b_eff;
    logic            c_eff;
    logic [7:0]      limb_a;
    logic [7:0]      limb_b;
    logic [7:0]      add_s;
    logic            add_co;

`ifdef ADD_SUB_EN
    // Subtract as A + ~B + 1; cin is deliberately ignored in that case.
    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? 1'b1 : cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_eff      = b;
    assign c_eff      = cin;
`endif

    assign limb_a = a_q[{idx, 3'b000} +: 8];
    assign limb_b = b_q[{idx, 3'b000} +: 8];

    add8 u_add8 (
        .x  (limb_a),
        .y  (limb_b),
        .ci (carry),
        .s  (add_s),
        .co (add_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        a_q   <= a;
                        b_q   <= b_eff;
                        carry <= c_eff;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    sum[{idx, 3'b000} +: 8] <= add_s;
                    carry <= add_co;
                    if (idx == LAST) begin
                        // Final limb: flags come straight from the top adder slice.
                        state <= DONE;
                        idx   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cout  <= add_co;
                        ovf   <= (a_q[W-1] == b_q[W-1]) && (add_s[7] != a_q[W-1]);
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        a_q   <= a;
                        b_q   <= b_eff;
                        carry <= c_eff;
                        idx   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multi_byte_add_seq.sv
// Self-checking bench for multi_byte_add_seq (NBYTES=4); results go through an expected queue.
// Honours ADD_SUB_EN when the bench is built with the same define as the RTL.

module tb_multi_byte_add_seq;
    localparam int NB = 4;
    localparam int W  = 8 * NB;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int checks   = 0;
    int failures = 0;

    // Each entry is {ovf, cout, sum}.
    logic [W+1:0] exp_q[$];

    multi_byte_add_seq #(.NBYTES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic ms);
        logic [W-1:0] be;
        logic         c;
        logic [W:0]   r;
        logic         v;
        be = mb;
        c  = mc;
`ifdef ADD_SUB_EN
        if (ms) begin
            be = ~mb;
            c  = 1'b1;
        end
`else
        if (ms) be = mb;
`endif
        r = {1'b0, ma} + {1'b0, be} + {{W{1'b0}}, c};
        v = (ma[W-1] == be[W-1]) && (r[W-1] != ma[W-1]);
        return {v, r};
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                logic [W+1:0] e;
                e = exp_q.pop_front();
                check("sum", sum, e[W-1:0]);
                check("cout", cout, e[W]);
                check("ovf", ovf, e[W+1]);
                check("busy_at_done", busy, 0);
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                          input logic ts, input logic [W+1:0] e, input bit noise);
        int n;
        @(negedge clk);
        a = ta; b = tb_; cin = tc; sub = ts;
        exp_q.push_back(e);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        while (n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) check("busy_after_start", busy, 1);
            if (noise && (n == 1 || n == 2)) begin
                start = 1'b1;
                a = $urandom;
                b = $urandom;
            end
            if (noise && n == 3) start = 1'b0;
            if (done) break;
        end
        if (n >= 20) check("timeout", 1, 0);
        else check("latency", n, NB + 1);
    endtask

    initial begin
        int n;
        logic [W-1:0] ra, rb;
        logic rc, rs;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_cout", cout, 0);
        check("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b0, 32'h00000100}, 1'b0);
        run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, {1'b0, 1'b1, 32'h00000000}, 1'b0);
        run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {1'b1, 1'b0, 32'h80000000}, 1'b0);
        run_op(32'h12345678, 32'h11111111, 1'b1, 1'b0, {1'b0, 1'b0, 32'h2345678A}, 1'b1);
        repeat (3) @(negedge clk);
        check("hold_sum", sum, 32'h2345678A);
`ifdef ADD_SUB_EN
        run_op(32'd5, 32'd7, 1'b0, 1'b1, {1'b0, 1'b0, 32'hFFFFFFFE}, 1'b0);
        run_op(32'd7, 32'd5, 1'b0, 1'b1, {1'b0, 1'b1, 32'h00000002}, 1'b0);
`else
        run_op(32'd5, 32'd7, 1'b0, 1'b1, {1'b0, 1'b0, 32'h0000000C}, 1'b0);
`endif
        for (int i = 0; i < 10; i++) begin
            ra = $urandom; rb = $urandom;
            rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
            run_op(ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b0);
        end

        // Reset in the second RUN cycle abandons the operation.
        @(negedge clk);
        a = 32'h01010101; b = 32'h02020202; cin = 1'b0; sub = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_sum", sum, 0);
        check("midrun_rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        run_op(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0, 1'b0, {1'b0, 1'b1, 32'h00000000}, 1'b0);

        // Start held high: results back to back every NB+1 cycles.
        @(negedge clk);
        ra = $urandom; rb = $urandom;
        a = ra; b = rb; cin = 1'b0; sub = 1'b0;
        exp_q.push_back(model(ra, rb, 1'b0, 1'b0));
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (n < 20) begin
                @(negedge clk);
                n++;
                if (done) break;
            end
            if (n >= 20) check("b2b_timeout", 1, 0);
            else if (i > 0) check("b2b_interval", n, NB + 1);
            if (i < 3) begin
                ra = $urandom; rb = $urandom;
                a = ra; b = rb;
                exp_q.push_back(model(ra, rb, 1'b0, 1'b0));
            end else begin
                start = 1'b0;
            end
        end
        repeat (10) @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
